alu8_core: RTL and testbench

- Registered 8-bit integer ALU slice for the CPU datapath.
- Built from three internal sub-blocks: an 8-bit ripple-carry adder, an 8-bit subtractor, and an 8-way 8-bit result multiplexer.
- Takes operands plus an opcode and produces a result and four status flags (zero, carry, overflow, sign).
- All outputs are registered on one clock with a synchronous, active-high reset; the flag outputs feed the CPU flag register.

---
 rtl/alu8_core.sv | 179 +++++++++++++++++
 tb/tb_alu8_core.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu8_core.sv
// Registered 8-bit ALU slice: ripple adder, ripple subtractor and an 8-way result mux
// feeding a single register stage for result and the zero/carry/overflow/sign flags.

module alu8_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end
endmodule

// 8-bit ripple-carry chain built from full adders.
module alu8_ripple_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    localparam int unsigned W = 8;

    logic [W:0] carry_chain;

    assign carry_chain[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        alu8_full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_chain[i]),
            .s    (sum[i]),
            .cout (carry_chain[i+1])
        );
    end

    assign cout = carry_chain[W];
endmodule

// a - b as a + ~b + 1; carry out is high when no borrow occurs (a >= b unsigned).
module alu8_subtractor (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] diff,
    output logic       cout
);
    logic [7:0] b_inv;

    assign b_inv = ~b;

    alu8_ripple_adder u_chain (
        .a    (a),
        .b    (b_inv),
        .cin  (1'b1),
        .sum  (diff),
        .cout (cout)
    );
endmodule

module alu8_result_mux (
    input  logic [2:0] sel,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [7:0] in4,
    input  logic [7:0] in5,
    input  logic [7:0] in6,
    input  logic [7:0] in7,
    output logic [7:0] out_c
);
    always_comb begin
        out_c = 8'h00;
        case (sel)
            3'd0:    out_c = in0;
            3'd1:    out_c = in1;
            3'd2:    out_c = in2;
            3'd3:    out_c = in3;
            3'd4:    out_c = in4;
            3'd5:    out_c = in5;
            3'd6:    out_c = in6;
            default: out_c = in7;
        endcase
    end
endmodule

module alu8_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic       zero,
    output logic       carry,
    output logic       overflow,
    output logic       sign
);
    localparam int unsigned DW = 8;
    localparam logic [2:0]  OP_ADD = 3'd1;
    localparam logic [2:0]  OP_SUB = 3'd2;

    logic [DW-1:0] sum;
    logic          add_carry;
    logic [DW-1:0] diff;
    logic          sub_carry;
    logic [DW-1:0] mux_out;
    logic          eb;

    logic [DW-1:0] result_d,   result_q;
    logic          zero_d,     zero_q;
    logic          carry_d,    carry_q;
    logic          overflow_d, overflow_q;
    logic          sign_d,     sign_q;

    alu8_ripple_adder u_add (
        .a    (a),
        .b    (b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (add_carry)
    );

    alu8_subtractor u_sub (
        .a    (a),
        .b    (b),
        .diff (diff),
        .cout (sub_carry)
    );

    alu8_result_mux u_mux (
        .sel   (op),
        .in0   (b),
        .in1   (sum),
        .in2   (diff),
        .in3   (8'h00),
        .in4   (8'h00),
        .in5   (8'h00),
        .in6   (8'h00),
        .in7   (8'h00),
        .out_c (mux_out)
    );

    // Overflow uses one formula for every opcode; subtraction sees the inverted B sign.
    always_comb begin
        eb         = (op == OP_SUB) ? ~b[DW-1] : b[DW-1];
        result_d   = mux_out;
        carry_d    = (op == OP_ADD) ? add_carry : sub_carry;
        zero_d     = (mux_out == 8'h00);
        sign_d     = mux_out[DW-1];
        overflow_d = (a[DW-1] == eb) && (a[DW-1] != mux_out[DW-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= 8'h00;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            sign_q     <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            sign_q     <= sign_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign sign     = sign_q;
endmodule

// File: tb/tb_alu8_core.sv
// Bench for alu8_core: directed vectors with hand-computed expectations, then
// randomized back-to-back traffic against an arithmetic reference model.

module tb_alu8_core;
    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       sign;

    int n_compared;
    int n_mismatched;

    alu8_core dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow),
        .sign     (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {result, zero, carry, overflow, sign}.
    function automatic logic [11:0] pack(input logic [7:0] r, input logic z, input logic c,
                                         input logic v, input logic s);
        return {r, z, c, v, s};
    endfunction

    function automatic logic [11:0] observed();
        return {result, zero, carry, overflow, sign};
    endfunction

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic [2:0] mop);
        int ua, ub, sa, sb, full;
        logic [7:0] r;
        logic c, v;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = (ua >= ub);
        v = 1'b0;
        case (mop)
            3'd0: r = mb;
            3'd1: begin
                full = ua + ub;
                r = 8'(full);
                c = (full > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            3'd2: begin
                r = 8'(ua - ub);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            default: begin
                r = 8'h00;
                v = ma[7] & mb[7];
            end
        endcase
        return pack(r, (r == 8'h00), c, v, r[7]);
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got r=%02h z%b c%b v%b s%b, want r=%02h z%b c%b v%b s%b",
                     tag, obs[11:4], obs[3], obs[2], obs[1], obs[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] da, input logic [7:0] db,
                         input logic [2:0] dop);
        @(negedge clk);
        rst = r;
        a   = da;
        b   = db;
        op  = dop;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [7:0] da, input logic [7:0] db,
                           input logic [2:0] dop, input logic [11:0] exp);
        drive(1'b0, da, db, dop);
        check(tag, observed(), exp);
    endtask

    initial begin
        logic [11:0] exp_v;
        logic [11:0] held;
        logic [7:0]  ra, rb;
        logic [2:0]  rop;
        logic        rrst;
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        a   = 8'hA5;
        b   = 8'h3C;
        op  = 3'd1;

        drive(1'b1, 8'hA5, 8'h3C, 3'd1);
        check("reset_c1", observed(), pack(8'h00, 1, 0, 0, 0));
        drive(1'b1, 8'hFF, 8'h80, 3'd2);
        check("reset_c2", observed(), pack(8'h00, 1, 0, 0, 0));

        run_vec("add_1_2",     8'd1,   8'd2,   3'd1, pack(8'd3,   0, 0, 0, 0));
        run_vec("sub_1_2",     8'd1,   8'd2,   3'd2, pack(8'hFF,  0, 0, 0, 1));
        run_vec("sub_eq",      8'd100, 8'd100, 3'd2, pack(8'd0,   1, 1, 0, 0));
        run_vec("add_wrap",    8'd255, 8'd1,   3'd1, pack(8'd0,   1, 1, 0, 0));
        run_vec("add_ovf_pos", 8'd120, 8'd11,  3'd1, pack(8'd131, 0, 0, 1, 1));
        run_vec("add_ovf_neg", 8'd129, 8'd200, 3'd1, pack(8'd73,  0, 1, 1, 0));
        run_vec("sub_ovf_a",   8'd7,   8'd128, 3'd2, pack(8'd135, 0, 0, 1, 1));
        run_vec("sub_ovf_b",   8'd170, 8'd85,  3'd2, pack(8'd85,  0, 1, 1, 0));
        run_vec("pass",        8'd0,   8'h55,  3'd0, pack(8'h55,  0, 0, 0, 0));
        run_vec("rsvd5",       8'h10,  8'h20,  3'd5, pack(8'h00,  1, 0, 0, 0));
        run_vec("rsvd7_flags", 8'h90,  8'h80,  3'd7, pack(8'h00,  1, 1, 1, 0));

        // Outputs must not follow input changes between edges.
        held = observed();
        a  = 8'h7F;
        b  = 8'h01;
        op = 3'd1;
        #2;
        check("hold", observed(), held);

        for (int i = 0; i < 24; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rop  = 3'($urandom_range(0, 7));
            rrst = (i == 12);
            drive(rrst, ra, rb, rop);
            exp_v = rrst ? pack(8'h00, 1, 0, 0, 0) : model(ra, rb, rop);
            check(rrst ? "rand_rst" : $sformatf("rand%0d", i), observed(), exp_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
